ppu_scanline_det: RTL and testbench
===================================

# ppu_scanline_det

PPU-bus scanline detector for mappers whose IRQ counters are clocked by scanlines rather than PPU A12 edges. It watches PPU read strobes and recognises the three identical nametable fetches that end every rendered line. From these it produces a one-clock `line_tick`, a frame-start pulse, an in-frame flag and a scanline number. It sits directly upstream of the mapper IRQ counter stage, which consumes `line_tick`/`in_frame` in place of a filtered A12 edge.

## Interface
- `IDLE_M2`, default 3: number of M2 falling edges without a PPU read after which rendering is considered stopped.
- `clk` in 1: system clock; all logic runs on its rising edge.
- `map_rst` in 1: reset, synchronous and active-high.
- `cpu_m2` in 1: CPU M2, asynchronous to `clk`.
- `ppu_oe` in 1: PPU /RD, active-low, asynchronous.
- `ppu_addr` in 14: PPU address bus.
- `line_tick` out 1: one-clock pulse per detected scanline boundary.
- `frame_start` out 1: one-clock pulse on the first boundary of a frame; coincides with `line_tick`.
- `in_frame` out 1: rendering active.
- `scanline` out 8: current line index, 0 at frame start.

## Operation
- **Input synchronisation**
  - `ppu_oe` and `cpu_m2` pass through 2-flop synchronisers.
  - `rd_strobe` is the synced `ppu_oe` rising edge (end of read).
  - `m2_fall` is the synced M2 1→0 edge.
  - `ppu_addr` is delayed by the same two stages; the delayed value is sampled at `rd_strobe`.
- **Match tracking**
  - Registers: `last_addr[13:0]` and `match_ctr[1:0]`.
  - On each `rd_strobe` with sampled address A:
    - If A == `last_addr` and A[13:12] == 2'b10, then `match_ctr` <= `match_ctr` + 1, saturating at 2.
    - Otherwise `match_ctr` <= 0.
    - In both cases `last_addr` <= A.
- **Boundary detection**
  - A boundary occurs when `match_ctr` == 1 and the current strobe matches, i.e. on the third identical read.
  - A fourth or later identical read produces no further boundary (saturation).
- **Line state on a boundary**
  - If `in_frame` == 0: `in_frame` <= 1, `scanline` <= 0, pulse `frame_start` and `line_tick`.
  - Else: `scanline` <= `scanline` + 1, wrapping modulo 256; pulse `line_tick`.
- **Idle timeout**
  - `idle_ctr` (2 bits for the default, width $clog2(IDLE_M2+1)) clears on every `rd_strobe`.
  - Otherwise it increments on `m2_fall`, saturating at `IDLE_M2`.
  - Reaching `IDLE_M2` forces `in_frame` <= 0, `scanline` <= 0 and `match_ctr` <= 0.
- **Simultaneous events**
  - `rd_strobe` and `m2_fall` in the same cycle: the strobe wins; `idle_ctr` clears.
  - A boundary in the same cycle as idle expiry cannot occur, because the strobe clears idle.
- **Reset**
  - `map_rst` clears every register: `last_addr` = 0, counters = 0, all outputs 0.
  - Synchroniser flops also reset, to 1 for `ppu_oe` (idle-high) and 0 for M2.
  - Reset mid-frame aborts the frame; the next three identical nametable reads give `frame_start`.

## Timing
- Reset values: `line_tick` = 0, `frame_start` = 0, `in_frame` = 0, `scanline` = 0.
- Synchroniser latency is 2 clk from pin edge to `rd_strobe`/`m2_fall`.
- `line_tick` and `frame_start` are registered. They assert 1 clk after `rd_strobe` of the third matching read, i.e. 3 clk after the pin `ppu_oe` rise.
- `scanline` and `in_frame` update in the same cycle that `line_tick` asserts.
- Idle deassertion of `in_frame` is registered, 1 clk after the `m2_fall` that reaches `IDLE_M2`.
- Pulses are exactly one clk wide. Strobes closer than 3 clk apart are not supported; the PPU read period exceeds this.

## Structure
- Shared mapper package:
  - `localparam NT_SEL = 2'b10` (nametable A[13:12] pattern).
  - Default `IDLE_M2`.
- One sub-module, `sync_edge`: 2-flop synchroniser plus rise/fall detector with a parameterised reset level. It is instantiated for `ppu_oe` and `cpu_m2`.
- The rest is flat: match tracker, idle counter, line state register.

## Test plan
- **Frame start.** Reads $2000, $2000, $2000 after reset → one `frame_start` plus `line_tick`, `in_frame` = 1, `scanline` = 0.
- **Consecutive lines, no double-count.** Reads $23C0×3, then $1000, $2000×4 → first boundary sets `scanline` = 0; second gives `scanline` = 1 and exactly one `line_tick` (the fourth identical read is ignored).
- **Non-nametable match.** Reads $0FF0×3 → no tick. Reads $2400, $2401, $2400 → no tick.
- **Idle timeout.** Mid-frame at `scanline` = 5, 3 M2 falls with no reads → `in_frame` = 0, `scanline` = 0. Next $2000×3 → `frame_start`.
- **Strobe beats idle.** `rd_strobe` coincident with the third `m2_fall` → `in_frame` stays 1, `idle_ctr` = 0.
- **Reset mid-frame, then wrap.** `map_rst` at `scanline` = 100 → all outputs 0 next clk. Separately, 257 boundaries → `scanline` wraps to 0 with `in_frame` = 1 and no `frame_start`.

Source files
------------

// File: rtl/ppu_scanline_det_pkg.sv
// rtl/ppu_scanline_det_pkg.sv - shared mapper constants for the scanline detector
package ppu_scanline_det_pkg;

    localparam logic [1:0] NT_SEL      = 2'b10;
    localparam int         IDLE_M2_DEF = 3;

    function automatic logic is_nametable(input logic [13:0] addr);
        return addr[13:12] == NT_SEL;
    endfunction

endpackage

// File: rtl/ppu_scanline_det_sync_edge.sv
// rtl/ppu_scanline_det_sync_edge.sv - 2-flop synchroniser with selectable edge pulse
module sync_edge #(
    parameter logic RST_VAL  = 1'b0,
    parameter bit   DET_RISE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic s1;
    logic s2;
    logic s3;

    // s3 resets to the same level so leaving reset never fakes an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= RST_VAL;
            s2 <= RST_VAL;
            s3 <= RST_VAL;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_comb begin
        pulse = 1'b0;
        if (DET_RISE) pulse = s2 & ~s3;
        else          pulse = ~s2 & s3;
    end

endmodule

// File: rtl/ppu_scanline_det.sv
// rtl/ppu_scanline_det.sv - scanline boundary detector from triple nametable fetches
module ppu_scanline_det
    import ppu_scanline_det_pkg::*;
#(
    parameter int IDLE_M2 = IDLE_M2_DEF
) (
    input  logic        clk,
    input  logic        map_rst,
    input  logic        cpu_m2,
    input  logic        ppu_oe,
    input  logic [13:0] ppu_addr,
    output logic        line_tick,
    output logic        frame_start,
    output logic        in_frame,
    output logic [7:0]  scanline
);

    localparam int IDLE_W = $clog2(IDLE_M2 + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_M2);

    logic              rd_strobe;
    logic              m2_fall;
    logic [13:0]       addr_d1;
    logic [13:0]       addr_d2;
    logic [13:0]       last_addr;
    logic [1:0]        match_ctr;
    logic [IDLE_W-1:0] idle_ctr;

    logic              addr_match;
    logic              boundary;
    logic [1:0]        match_next;
    logic [IDLE_W-1:0] idle_next;
    logic              idle_hit;

    sync_edge #(.RST_VAL(1'b1), .DET_RISE(1'b1)) u_oe_sync (
        .clk   (clk),
        .rst   (map_rst),
        .din   (ppu_oe),
        .pulse (rd_strobe)
    );

    sync_edge #(.RST_VAL(1'b0), .DET_RISE(1'b0)) u_m2_sync (
        .clk   (clk),
        .rst   (map_rst),
        .din   (cpu_m2),
        .pulse (m2_fall)
    );

    // Address follows the same two-stage delay so it lines up with rd_strobe
    always_ff @(posedge clk) begin
        if (map_rst) begin
            addr_d1 <= '0;
            addr_d2 <= '0;
        end else begin
            addr_d1 <= ppu_addr;
            addr_d2 <= addr_d1;
        end
    end

    always_comb begin
        addr_match = (addr_d2 == last_addr) && is_nametable(addr_d2);
        boundary   = rd_strobe && addr_match && (match_ctr == 2'd1);
        match_next = 2'd0;
        if (addr_match) begin
            match_next = (match_ctr == 2'd2) ? 2'd2 : match_ctr + 2'd1;
        end
    end

    // A read strobe always wins over an M2 fall in the same cycle
    always_comb begin
        idle_next = idle_ctr;
        if (rd_strobe) begin
            idle_next = '0;
        end else if (m2_fall && (idle_ctr != IDLE_MAX)) begin
            idle_next = idle_ctr + 1'b1;
        end
        idle_hit = (idle_next == IDLE_MAX);
    end

    always_ff @(posedge clk) begin
        if (map_rst) begin
            last_addr   <= '0;
            match_ctr   <= '0;
            idle_ctr    <= '0;
            line_tick   <= 1'b0;
            frame_start <= 1'b0;
            in_frame    <= 1'b0;
            scanline    <= '0;
        end else begin
            line_tick   <= 1'b0;
            frame_start <= 1'b0;
            idle_ctr    <= idle_next;
            if (rd_strobe) begin
                last_addr <= addr_d2;
                match_ctr <= match_next;
                if (boundary) begin
                    line_tick <= 1'b1;
                    if (!in_frame) begin
                        in_frame    <= 1'b1;
                        scanline    <= '0;
                        frame_start <= 1'b1;
                    end else begin
                        scanline <= scanline + 8'd1;
                    end
                end
            end else if (idle_hit) begin
                in_frame  <= 1'b0;
                scanline  <= '0;
                match_ctr <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ppu_scanline_det.sv
// tb/tb_ppu_scanline_det.sv - randomized bench against a run-length scanline model
module tb_ppu_scanline_det;

    logic        clk = 1'b0;
    logic        map_rst;
    logic        cpu_m2;
    logic        ppu_oe;
    logic [13:0] ppu_addr;
    logic        line_tick;
    logic        frame_start;
    logic        in_frame;
    logic [7:0]  scanline;

    int total = 0;
    int bad = 0;
    int fs_seen = 0;

    // Reference: length of the current run of identical reads, idle M2 count, line state
    logic [13:0] m_prev;
    int          m_run;
    int          m_idle;
    bit          m_in;
    int          m_line;

    ppu_scanline_det dut (
        .clk         (clk),
        .map_rst     (map_rst),
        .cpu_m2      (cpu_m2),
        .ppu_oe      (ppu_oe),
        .ppu_addr    (ppu_addr),
        .line_tick   (line_tick),
        .frame_start (frame_start),
        .in_frame    (in_frame),
        .scanline    (scanline)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_prev = 14'h0000;
        m_run  = 1;
        m_idle = 0;
        m_in   = 1'b0;
        m_line = 0;
    endtask

    task automatic model_read(input logic [13:0] a, output bit exp_tick, output bit exp_fs);
        exp_tick = 1'b0;
        exp_fs   = 1'b0;
        m_idle   = 0;
        if (a == m_prev && a[13:12] == 2'b10) m_run++;
        else                                  m_run = 1;
        m_prev = a;
        if (m_run == 3) begin
            exp_tick = 1'b1;
            if (!m_in) begin
                m_in   = 1'b1;
                m_line = 0;
                exp_fs = 1'b1;
            end else begin
                m_line = (m_line + 1) % 256;
            end
        end
    endtask

    task automatic model_m2();
        if (m_idle < 3) m_idle++;
        if (m_idle == 3) begin
            m_in   = 1'b0;
            m_line = 0;
            m_run  = 1;
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [13:0] a, input bit with_m2);
        bit et;
        bit ef;
        int th = 0;
        int fh = 0;
        int at = 0;
        ppu_addr = a;
        if (with_m2) cpu_m2 = 1'b1;
        clocks(1);
        ppu_oe = 1'b0;
        clocks(3);
        ppu_oe = 1'b1;
        if (with_m2) cpu_m2 = 1'b0;
        model_read(a, et, ef);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            if (line_tick) begin
                th++;
                at = k;
            end
            if (frame_start) fh++;
        end
        fs_seen += fh;
        check_eq("tick_cnt", th, et);
        check_eq("fs_cnt", fh, ef);
        if (et) check_eq("tick_lat", at, 3);
        check_eq("in_frame", in_frame, m_in);
        check_eq("scanline", scanline, m_line);
    endtask

    task automatic m2();
        cpu_m2 = 1'b1;
        clocks(3);
        cpu_m2 = 1'b0;
        clocks(4);
        model_m2();
        check_eq("m2_in_frame", in_frame, m_in);
        check_eq("m2_scanline", scanline, m_line);
    endtask

    task automatic line();
        rd(14'h1000, 1'b0);
        repeat (3) rd(14'h2000, 1'b0);
    endtask

    task automatic do_reset();
        map_rst = 1'b1;
        clocks(1);
        check_eq("rst_tick", line_tick, 0);
        check_eq("rst_fs", frame_start, 0);
        check_eq("rst_in_frame", in_frame, 0);
        check_eq("rst_scanline", scanline, 0);
        map_rst = 1'b0;
        model_reset();
        clocks(2);
    endtask

    initial begin
        logic [13:0] pool [7];
        logic [13:0] a;
        int fs_before;
        int r;
        pool[0] = 14'h2000; pool[1] = 14'h23C0; pool[2] = 14'h2400; pool[3] = 14'h2401;
        pool[4] = 14'h0FF0; pool[5] = 14'h1000; pool[6] = 14'h3000;
        map_rst  = 1'b1;
        cpu_m2   = 1'b0;
        ppu_oe   = 1'b1;
        ppu_addr = 14'h0000;
        clocks(3);
        do_reset();

        repeat (3) rd(14'h2000, 1'b0);
        repeat (3) rd(14'h23C0, 1'b0);
        rd(14'h1000, 1'b0);
        repeat (4) rd(14'h2000, 1'b0);
        repeat (3) rd(14'h0FF0, 1'b0);
        rd(14'h2400, 1'b0);
        rd(14'h2401, 1'b0);
        rd(14'h2400, 1'b0);

        while (m_line < 5) line();
        repeat (3) m2();
        repeat (3) rd(14'h2000, 1'b0);

        m2();
        m2();
        rd(14'h1000, 1'b1);
        m2();
        m2();
        m2();

        do_reset();
        repeat (3) rd(14'h2000, 1'b0);
        while (m_line < 100) line();
        do_reset();

        repeat (3) rd(14'h2000, 1'b0);
        fs_before = fs_seen;
        repeat (256) line();
        check_eq("wrap_scanline", scanline, 0);
        check_eq("wrap_in_frame", in_frame, 1);
        check_eq("wrap_no_fs", fs_seen - fs_before, 0);

        a = 14'h2000;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 10) begin
                m2();
            end else begin
                if (r >= 60) a = pool[$urandom_range(0, 6)];
                rd(a, r < 16);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
